// File: rtl/four_to_two_encoder_if.sv
// Purpose : Handshake bundle for the one-hot to binary encoder.
// Ports   : producer side  - in_valid, in_ready, W, X, Y, Z
//           consumer side  - out_valid, out_ready, A, B, out_err
//           master modport is the environment (drives words in, accepts
//           results); slave modport is the encoder itself.
interface four_to_two_encoder_if;
    logic in_valid;
    logic in_ready;
    logic W;
    logic X;
    logic Y;
    logic Z;
    logic out_valid;
    logic out_ready;
    logic A;
    logic B;
    logic out_err;

    modport master (
        output in_valid, W, X, Y, Z, out_ready,
        input  in_ready, out_valid, A, B, out_err
    );

    modport slave (
        input  in_valid, W, X, Y, Z, out_ready,
        output in_ready, out_valid, A, B, out_err
    );
endinterface

// File: rtl/four_to_two_encoder.sv
// Purpose : Encodes a one-hot word {W,X,Y,Z} into a 2-bit code {A,B} with an
//           error flag for non-one-hot input, buffers results in a 2-entry
//           in-order FIFO and keeps a saturating count of erroneous words.
// Ports   : clk       - rising-edge clock
//           rst       - synchronous active-high reset
//           bus       - slave side of four_to_two_encoder_if (valid/ready
//                       handshakes on input and output)
//           err_count - saturating count of accepted words flagged out_err
module four_to_two_encoder #(
    parameter int ERR_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    four_to_two_encoder_if.slave bus,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    typedef struct packed {
        logic [1:0] code;
        logic       err;
    } word_t;

    occ_t  state;
    occ_t  state_nxt;
    word_t head;
    word_t tail;
    word_t in_word;
    logic  push;
    logic  pop;

    // Highest set line wins; anything other than exactly one set line
    // (including all-zero, which encodes 00) is flagged as an error.
    function automatic word_t encode(input logic w, input logic x,
                                     input logic y, input logic z);
        word_t r;
        casez ({w, x, y, z})
            4'b???1: r.code = 2'b11;
            4'b??10: r.code = 2'b10;
            4'b?100: r.code = 2'b01;
            default: r.code = 2'b00;
        endcase
        case ({w, x, y, z})
            4'b1000, 4'b0100, 4'b0010, 4'b0001: r.err = 1'b0;
            default:                            r.err = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign in_word = encode(bus.W, bus.X, bus.Y, bus.Z);

    // Handshakes; in_ready already carries the reset gate, so no push can
    // land during reset, and pops are blocked explicitly.
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready && !rst;

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Occupancy next state
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (push) state_nxt = ONE;
            ONE: begin
                if (push && !pop)      state_nxt = TWO;
                else if (!push && pop) state_nxt = EMPTY;
            end
            TWO:     if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // Outputs; when empty the result lines are forced low so no stale
    // storage content is ever visible (storage itself is not reset).
    always_comb begin
        bus.in_ready  = !rst && (state != TWO);
        bus.out_valid = (state != EMPTY);
        bus.A         = 1'b0;
        bus.B         = 1'b0;
        bus.out_err   = 1'b0;
        if (state != EMPTY) begin
            bus.A       = head.code[1];
            bus.B       = head.code[0];
            bus.out_err = head.err;
        end
    end

    // FIFO storage: head is the oldest word, tail the second one.
    always_ff @(posedge clk) begin
        if (push && ((state == EMPTY) || ((state == ONE) && pop))) begin
            head <= in_word;
        end else if (pop && (state == TWO)) begin
            head <= tail;
        end
        if (push && (state == ONE) && !pop) begin
            tail <= in_word;
        end
    end

    // Error count is taken at accept time, not when the word leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (push && in_word.err) begin
            err_count <= sat_inc(err_count);
        end
    end

endmodule

// File: tb/tb_four_to_two_encoder.sv
module tb_four_to_two_encoder;

    localparam int ERR_CNT_W = 4;
    localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

    logic clk;
    logic rst;
    logic [ERR_CNT_W-1:0] err_count;

    four_to_two_encoder_if bus ();

    four_to_two_encoder #(.ERR_CNT_W(ERR_CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] wxyz;
        logic [1:0] ab;
        logic       err;
    } vec_t;

    typedef struct {
        int code;
        int err;
    } mword_t;

    int checks   = 0;
    int failures = 0;

    mword_t mq[$];
    int     mcnt = 0;

    vec_t tbl [16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding from the rules: index of the highest set line
    // (W=0 .. Z=3), error unless exactly one line is set.
    function automatic mword_t model_encode(input logic [3:0] wxyz);
        mword_t r;
        logic [3:0] lines;
        lines  = {wxyz[0], wxyz[1], wxyz[2], wxyz[3]};
        r.code = 0;
        for (int i = 0; i < 4; i++) begin
            if (lines[i]) r.code = i;
        end
        r.err = ($countones(lines) == 1) ? 0 : 1;
        return r;
    endfunction

    task automatic drive(input logic iv, input logic [3:0] wxyz, input logic ordy);
        bus.in_valid  = iv;
        bus.W         = wxyz[3];
        bus.X         = wxyz[2];
        bus.Y         = wxyz[1];
        bus.Z         = wxyz[0];
        bus.out_ready = ordy;
    endtask

    // One clock: compare DUT against the model on the falling edge, then
    // advance the model by the handshakes seen on the rising edge.
    task automatic cycle();
        bit push;
        bit pop;
        mword_t w;
        @(negedge clk);
        chk("in_ready", int'(bus.in_ready), (!rst && mq.size() < 2) ? 1 : 0);
        chk("out_valid", int'(bus.out_valid), (mq.size() > 0) ? 1 : 0);
        chk("err_count", int'(err_count), mcnt);
        if (mq.size() > 0) begin
            chk("head_code", int'({bus.A, bus.B}), mq[0].code);
            chk("head_err", int'(bus.out_err), mq[0].err);
        end
        push = bus.in_valid && (mq.size() < 2) && !rst;
        pop  = bus.out_ready && (mq.size() > 0) && !rst;
        w    = model_encode({bus.W, bus.X, bus.Y, bus.Z});
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mcnt = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(w);
                if (w.err != 0 && mcnt < CNT_MAX) mcnt++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 4'b0000, 1'b0);
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{4'b0000, 2'b00, 1'b1};
        tbl[1]  = '{4'b0001, 2'b11, 1'b0};
        tbl[2]  = '{4'b0010, 2'b10, 1'b0};
        tbl[3]  = '{4'b0011, 2'b11, 1'b1};
        tbl[4]  = '{4'b0100, 2'b01, 1'b0};
        tbl[5]  = '{4'b0101, 2'b11, 1'b1};
        tbl[6]  = '{4'b0110, 2'b10, 1'b1};
        tbl[7]  = '{4'b0111, 2'b11, 1'b1};
        tbl[8]  = '{4'b1000, 2'b00, 1'b0};
        tbl[9]  = '{4'b1001, 2'b11, 1'b1};
        tbl[10] = '{4'b1010, 2'b10, 1'b1};
        tbl[11] = '{4'b1011, 2'b11, 1'b1};
        tbl[12] = '{4'b1100, 2'b01, 1'b1};
        tbl[13] = '{4'b1101, 2'b11, 1'b1};
        tbl[14] = '{4'b1110, 2'b10, 1'b1};
        tbl[15] = '{4'b1111, 2'b11, 1'b1};

        rst = 1'b1;
        drive(1'b0, 4'b0000, 1'b0);
        cycle();
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_ab", int'({bus.A, bus.B}), 0);
        chk("rst_out_err", int'(bus.out_err), 0);
        chk("rst_err_count", int'(err_count), 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", int'(bus.in_ready), 1);

        // Basic one-hot sequence, each result one cycle after accept.
        for (int i = 0; i < 4; i++) begin
            logic [3:0] oh;
            oh = 4'b1000 >> i;
            drive(1'b1, oh, 1'b1);
            cycle();
            chk("seq_valid", int'(bus.out_valid), 1);
            chk("seq_ab", int'({bus.A, bus.B}), i);
            chk("seq_err", int'(bus.out_err), 0);
        end
        drive(1'b0, 4'b0000, 1'b1);
        cycle();
        chk("seq_err_count", int'(err_count), 0);

        // Full truth table.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, tbl[i].wxyz, 1'b1);
            cycle();
            chk("tbl_valid", int'(bus.out_valid), 1);
            chk("tbl_ab", int'({bus.A, bus.B}), int'(tbl[i].ab));
            chk("tbl_err", int'(bus.out_err), int'(tbl[i].err));
            drive(1'b0, 4'b0000, 1'b1);
            cycle();
        end

        // Backpressure: fill, hold, ignore third push, then drain.
        do_reset();
        drive(1'b1, 4'b0100, 1'b0);
        cycle();
        drive(1'b1, 4'b0001, 1'b0);
        cycle();
        chk("bp_in_ready", int'(bus.in_ready), 0);
        chk("bp_ab", int'({bus.A, bus.B}), 1);
        drive(1'b1, 4'b1000, 1'b0);
        cycle();
        cycle();
        chk("bp_hold_ab", int'({bus.A, bus.B}), 1);
        drive(1'b1, 4'b1000, 1'b1);
        cycle();
        chk("bp_pop_no_push", int'({bus.A, bus.B}), 3);
        drive(1'b0, 4'b0000, 1'b1);
        cycle();
        chk("bp_drained", int'(bus.out_valid), 0);
        chk("bp_ready_again", int'(bus.in_ready), 1);

        // Error words and error counting.
        drive(1'b1, 4'b0110, 1'b1);
        cycle();
        chk("err_ab0", int'({bus.A, bus.B}), 2);
        chk("err_flag0", int'(bus.out_err), 1);
        drive(1'b1, 4'b0000, 1'b1);
        cycle();
        chk("err_ab1", int'({bus.A, bus.B}), 0);
        chk("err_flag1", int'(bus.out_err), 1);
        chk("err_count2", int'(err_count), 2);

        // Saturation.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 4'b0000, 1'b1);
            cycle();
        end
        drive(1'b0, 4'b0000, 1'b1);
        cycle();
        chk("err_sat", int'(err_count), CNT_MAX);

        // Reset while holding two words.
        drive(1'b1, 4'b0010, 1'b0);
        cycle();
        drive(1'b1, 4'b0001, 1'b0);
        cycle();
        chk("two_full", int'(bus.in_ready), 0);
        rst = 1'b1;
        drive(1'b0, 4'b0000, 1'b1);
        cycle();
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", int'(bus.out_valid), 0);
        chk("mid_rst_ab", int'({bus.A, bus.B}), 0);
        chk("mid_rst_err", int'(bus.out_err), 0);
        chk("mid_rst_count", int'(err_count), 0);
        chk("mid_rst_ready", int'(bus.in_ready), 1);
        cycle();
        chk("no_stale", int'(bus.out_valid), 0);

        // Streaming: one word per cycle, occupancy stays ONE.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'b1000 >> (i % 4), 1'b1);
            cycle();
            chk("stream_ab", int'({bus.A, bus.B}), i % 4);
            chk("stream_ready", int'(bus.in_ready), 1);
        end
        drive(1'b0, 4'b0000, 1'b1);
        cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 2) != 0));
            cycle();
        end
        rst = 1'b0;
        drive(1'b0, 4'b0000, 1'b1);
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/four_to_two_encoder.md
FOUR_TO_TWO_ENCODER -- requirements
Module: four_to_two_encoder

Interface
REQ-001 Parameter: ERR_CNT_W, default 4, width of the saturating error counter.
REQ-002 clk  input  1  Single clock; all state updates on rising edge.
REQ-003 rst  input  1  Reset; synchronous, active-high.
REQ-004 in_valid  input  1  Producer has a one-hot word on W,X,Y,Z.
REQ-005 in_ready  output  1  Block can accept a word this cycle.
REQ-006 W  input  1  One-hot line for code 00.
REQ-007 X  input  1  One-hot line for code 01.
REQ-008 Y  input  1  One-hot line for code 10.
REQ-009 Z  input  1  One-hot line for code 11.
REQ-010 out_valid  output  1  A,B,out_err hold a valid encoded word.
REQ-011 out_ready  input  1  Consumer accepts the word this cycle.
REQ-012 A  output  1  Encoded MSB.
REQ-013 B  output  1  Encoded LSB.
REQ-014 out_err  output  1  Word's input was not one-hot.
REQ-015 err_count  output  ERR_CNT_W  Saturating count of erroneous accepted words.

Function
REQ-016 Input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; output transfer on a rising edge where out_valid=1 and out_ready=1.
REQ-017 Encoding SHALL be {W,X,Y,Z}=1000->{A,B}=00, 0100->01, 0010->10, 0001->11, with out_err=0.
REQ-018 Non-one-hot input SHALL encode by priority Z>Y>X>W (highest set line wins) with out_err=1; all-zero input SHALL encode 00 with out_err=1.
REQ-019 Accepted words SHALL pass through a 2-entry FIFO in strict arrival order; occupancy states EMPTY(0), ONE(1), TWO(2).
REQ-020 Transitions: push only -> occupancy+1; pop only -> occupancy-1; push and pop together -> unchanged; neither -> unchanged.
REQ-021 in_ready SHALL equal (occupancy != TWO) and SHALL NOT depend on out_ready; in TWO a same-cycle pop does not permit a push.
REQ-022 out_valid SHALL equal (occupancy != EMPTY); A,B,out_err SHALL reflect the FIFO head entry.
REQ-023 Latency: a word accepted in EMPTY SHALL appear with out_valid=1 on the cycle after the accepting edge (1 cycle).
REQ-024 While out_valid=1 and out_ready=0, A,B,out_err SHALL remain stable.
REQ-025 Push and pop in ONE SHALL present the new word at the head after the edge, with occupancy staying ONE.
REQ-026 err_count SHALL increment by 1 on each accepted word with out_err=1, computed at accept time, and SHALL saturate at 2^ERR_CNT_W-1 (no wrap).
REQ-027 Inputs W,X,Y,Z SHALL be ignored when no input transfer occurs.

Reset
REQ-028 With rst=1 at a rising edge: occupancy->EMPTY, out_valid=0, A=0, B=0, out_err=0, err_count=0; FIFO contents discarded.
REQ-029 While rst=1, no push or pop SHALL take effect and in_ready SHALL be 0; in_ready=1 from the first cycle after rst deasserts.
REQ-030 Reset asserted mid-operation (occupancy ONE or TWO) SHALL drop all pending words; none appear after reset.

Verification
REQ-031 Reset, then push W,X,Y,Z=1000/0100/0010/0001 with out_ready=1 -> A,B sequence 00,01,10,11, out_err=0, each 1 cycle after accept, err_count=0.
REQ-032 out_ready=0, push 0100 then 0001 -> in_ready=0 after second push, out A,B=01 held stable; third push ignored; raise out_ready -> 01 then 11 delivered, in_ready=1 again.
REQ-033 Push 0110 and 0000 -> A,B=10 out_err=1, then 00 out_err=1; err_count=2.
REQ-034 ERR_CNT_W=4, push 20 all-zero words -> err_count stops at 15.
REQ-035 Occupancy TWO, assert rst for 1 cycle -> out_valid=0, A=B=0, err_count=0, in_ready=1 next cycle; no stale word emitted.
REQ-036 Continuous in_valid=1, out_ready=1 for 8 words -> one word per cycle, occupancy remains ONE, order preserved.
